// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INC     = 4;
  localparam logic [31:0] TRAP_VEC   = 32'h0000_0080;
  // Low PC bits that must be zero for a word-aligned fetch target.
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_incrementer.sv
// XLEN-wide PC + INC adder; wraps modulo 2^XLEN.
module pc_incrementer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned INC  = 4
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_inc_o
);

  assign pc_inc_o = pc_i + XLEN'(INC);

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: BOOT/RUN/HOLD handshake with stall and redirect, state on falling edge.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_gen #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     INC      = pc_pkg::PC_INC,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(pc_pkg::TRAP_VEC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            if_ready_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_addr_o,
  output logic [XLEN-1:0] pc_inc_o,
  output logic [31:0]     fetch_cnt_o,
  output logic            misalign_o
);

  import pc_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] pc_inc;
  logic            fire;

  pc_incrementer #(.XLEN(XLEN), .INC(INC)) u_inc (
    .pc_i     (pc_q),
    .pc_inc_o (pc_inc)
  );

  // A stalled cycle never counts as an accepted fetch, even with ready high.
  assign fire = if_ready_i & ~stall_i;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    if_valid_o = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if_valid_o = 1'b1;
        if (redirect_i) begin
          state_d = RUN;
`ifdef PC_MISALIGN_TRAP_EN
          if ((redirect_pc_i[1:0] & ALIGN_MASK) != 2'b00) begin
            pc_d       = TRAP_VEC;
            misalign_d = 1'b1;
          end else begin
            pc_d = redirect_pc_i;
          end
`else
          pc_d = redirect_pc_i;
`endif
        end else if (fire) begin
          state_d = RUN;
          pc_d    = pc_inc;
          cnt_d   = cnt_q + 32'd1;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign if_addr_o   = pc_q;
  assign pc_inc_o    = pc_inc;
  assign fetch_cnt_o = cnt_q;

endmodule
